// File: rtl/ham_run_ctrl.sv
// Run sequencer for the Hamming min/max program: loads operands, presets the result area,
// launches the core, reads back Min/Max. Optional RUN watchdog: define HAM_RUN_TIMEOUT_EN.
module ham_run_ctrl #(
  parameter int NUM_BYTES  = 64,
  parameter int MEM_DEPTH  = 256,
  parameter int RES_BASE   = 64,
  parameter int START_HOLD = 2,
  parameter int DONE_GUARD = 2
`ifdef HAM_RUN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_sel,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       cpu_start,
  input  logic       cpu_done,
  output logic       busy,
  output logic       res_valid,
  output logic [4:0] res_min,
  output logic [4:0] res_max,
  output logic       res_err
`ifdef HAM_RUN_TIMEOUT_EN
  , output logic     timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PRESET, LAUNCH, RUN, READ_MIN, READ_MAX, REPORT
  } state_t;

  localparam logic [8:0] LAST_BYTE = 9'(NUM_BYTES - 1);
  localparam logic [8:0] LAST_ADDR = 9'(MEM_DEPTH - 1);
  localparam logic [8:0] RES_ADDR  = 9'(RES_BASE);
  localparam logic [7:0] MIN_ADDR  = 8'(RES_BASE);
  localparam logic [7:0] MAX_ADDR  = 8'(RES_BASE + 1);
  localparam logic [8:0] HOLD_LAST = 9'(START_HOLD);
  localparam logic [8:0] GUARD     = 9'(DONE_GUARD);

  state_t     state, state_next;
  logic [8:0] cnt, cnt_next;
  logic [7:0] min_r, min_next;
  logic [4:0] res_min_reg, res_min_next;
  logic [4:0] res_max_reg, res_max_next;
  logic       res_err_reg, res_err_next;
`ifdef HAM_RUN_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer, timer_next;
  logic        timed_out, timed_out_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      min_r       <= '0;
      res_min_reg <= '0;
      res_max_reg <= '0;
      res_err_reg <= 1'b0;
`ifdef HAM_RUN_TIMEOUT_EN
      timer       <= '0;
      timed_out   <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      min_r       <= min_next;
      res_min_reg <= res_min_next;
      res_max_reg <= res_max_next;
      res_err_reg <= res_err_next;
`ifdef HAM_RUN_TIMEOUT_EN
      timer       <= timer_next;
      timed_out   <= timed_out_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    min_next     = min_r;
    res_min_next = res_min_reg;
    res_max_next = res_max_reg;
    res_err_next = res_err_reg;
`ifdef HAM_RUN_TIMEOUT_EN
    timer_next     = timer;
    timed_out_next = timed_out;
`endif
    in_ready  = 1'b0;
    mem_sel   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_start = 1'b1;

    case (state)
      IDLE: begin
        if (go) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = cnt[7:0];
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          cnt_next  = cnt + 9'd1;
          if (cnt == LAST_BYTE) state_next = PRESET;
        end
      end
      PRESET: begin
        mem_we    = 1'b1;
        mem_addr  = cnt[7:0];
        mem_wdata = (cnt == RES_ADDR) ? 8'd16 : 8'd0;
        if (cnt == LAST_ADDR) begin
          state_next = LAUNCH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 9'd1;
        end
      end
      LAUNCH: begin
        // First cycle hands the port to the core; start is then held START_HOLD more cycles.
        mem_sel = 1'b0;
        if (cnt == HOLD_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
`ifdef HAM_RUN_TIMEOUT_EN
          timer_next     = '0;
          timed_out_next = 1'b0;
`endif
        end else begin
          cnt_next = cnt + 9'd1;
        end
      end
      RUN: begin
        mem_sel   = 1'b0;
        cpu_start = 1'b0;
        if (cnt < GUARD) cnt_next = cnt + 9'd1;
        // A done seen inside the guard window is a leftover from the previous run.
        if (cpu_done && cnt >= GUARD) begin
          state_next = READ_MIN;
        end
`ifdef HAM_RUN_TIMEOUT_EN
        else if (timer == TIMER_LAST) begin
          state_next     = READ_MIN;
          timed_out_next = 1'b1;
        end
        timer_next = timer + 16'd1;
`endif
      end
      READ_MIN: begin
        mem_addr   = MIN_ADDR;
        min_next   = mem_rdata;
        state_next = READ_MAX;
      end
      READ_MAX: begin
        mem_addr     = MAX_ADDR;
        res_min_next = min_r[4:0];
        res_max_next = mem_rdata[4:0];
        res_err_next = (min_r > 8'd16) || (mem_rdata > 8'd16) || (min_r > mem_rdata);
`ifdef HAM_RUN_TIMEOUT_EN
        if (timed_out) res_err_next = 1'b1;
`endif
        state_next = REPORT;
      end
      REPORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == REPORT);
  assign res_min   = res_min_reg;
  assign res_max   = res_max_reg;
  assign res_err   = res_err_reg;
`ifdef HAM_RUN_TIMEOUT_EN
  assign timeout   = (state == REPORT) && timed_out;
`endif

endmodule

// File: tb/tb_ham_run_ctrl.sv
// Bench for ham_run_ctrl: memory and core models, expected reports queued on issue and
// compared by a separate monitor whenever res_valid is seen.
module tb_ham_run_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, mem_sel, mem_we, cpu_start, busy, res_valid, res_err;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       cpu_done = 1'b0;
  logic [4:0] res_min, res_max;
`ifdef HAM_RUN_TIMEOUT_EN
  logic       timeout;
`endif

  logic [7:0] dm [256];
  logic       core_we = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0;
  logic [7:0] exp_bytes [64];

  typedef struct packed {
    logic [4:0] mn;
    logic [4:0] mx;
    logic       err;
    logic       tmo;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef HAM_RUN_TIMEOUT_EN
  ham_run_ctrl #(.TIMEOUT_CYCLES(100)) dut (
`else
  ham_run_ctrl dut (
`endif
    .clk(clk), .reset(reset), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .busy(busy), .res_valid(res_valid), .res_min(res_min),
    .res_max(res_max), .res_err(res_err)
`ifdef HAM_RUN_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // Shared data memory: controller port when mem_sel=1, core model otherwise.
  assign mem_rdata = dm[mem_addr];
  always @(posedge clk) begin
    if (mem_sel && mem_we) dm[mem_addr] <= mem_wdata;
    else if (!mem_sel && core_we) dm[core_addr] <= core_wdata;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] mn, input logic [4:0] mx,
                              input logic err, input logic tmo);
    exp_t r;
    r.mn = mn; r.mx = mx; r.err = err; r.tmo = tmo;
    return r;
  endfunction

  // Monitor: one line per report, compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      $display("report: min=%0d max=%0d err=%0d", res_min, res_max, res_err);
      if (q.size() == 0) begin
        check("unexpected_report", 1, 0);
      end else begin
        e = q.pop_front();
        check("res_min", int'(res_min), int'(e.mn));
        check("res_max", int'(res_max), int'(e.mx));
        check("res_err", int'(res_err), int'(e.err));
`ifdef HAM_RUN_TIMEOUT_EN
        check("timeout", int'(timeout), int'(e.tmo));
`endif
      end
    end
  end

  task automatic start_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("load_in_ready", int'(in_ready), 1);
  endtask

  task automatic load_bytes(input int gap, input logic [7:0] seed);
    for (int i = 0; i < 64; i++) begin
      if (gap != 0 && (i % gap) == gap - 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = seed + 8'(i * 7);
      exp_bytes[i] = in_data;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("in_ready_after_load", int'(in_ready), 0);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (cpu_start !== 1'b0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("start_fall_timeout", n, 0);
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    core_we = 1'b1; core_addr = a; core_wdata = d;
    @(posedge clk); #1;
    core_we = 1'b0;
  endtask

  task automatic done_pulse();
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
  endtask

  task automatic wait_report(input int limit, input int exp_min);
    int n;
    n = 0;
    while (!res_valid && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("report_seen", int'(res_valid), 1);
    @(posedge clk); #1;
    check("res_valid_pulse", int'(res_valid), 0);
    check("busy_after_report", int'(busy), 0);
    check("res_min_hold", int'(res_min), exp_min);
  endtask

  // Plain run: core writes results, then a single done after the guard.
  task automatic run_simple(input logic [7:0] w64, input logic [7:0] w65,
                            input logic [4:0] mn, input logic [4:0] mx, input logic err);
    int n;
    start_go();
    load_bytes(0, w64 ^ w65);
    wait_fall(n);
    core_write(8'd64, w64);
    core_write(8'd65, w65);
    q.push_back(mk(mn, mx, err, 1'b0));
    @(posedge clk); #1;
    done_pulse();
    wait_report(20, int'(mn));
  endtask

  initial begin
    int n, bad, nz;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_start", int'(cpu_start), 1);
    check("rst_mem_sel", int'(mem_sel), 1);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_min", int'(res_min), 0);
    check("rst_res_max", int'(res_max), 0);
    check("rst_res_err", int'(res_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Abort mid-PRESET after 50 preset writes.
    start_go();
    load_bytes(0, 8'h5a);
    repeat (50) @(posedge clk);
    #1;
    check("preset_we", int'(mem_we), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_cpu_start", int'(cpu_start), 1);
    check("abort_mem_we", int'(mem_we), 0);
    check("abort_mem_sel", int'(mem_sel), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Full run with in_valid gaps, stale early done, results 3/14.
    start_go();
    load_bytes(3, 8'h11);
    wait_fall(n);
    check("start_fall_latency", n, 195);
    check("run_mem_sel", int'(mem_sel), 0);
    @(posedge clk); #1;
    done_pulse();
    check("early_done_ignored", int'(cpu_start), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (dm[i] !== exp_bytes[i]) bad++;
    check("dm_operands", bad, 0);
    check("dm_min_preset", int'(dm[64]), 16);
    nz = 0;
    for (int i = 65; i < 256; i++) if (dm[i] !== 8'd0) nz++;
    check("dm_zero_preset", nz, 0);
    core_write(8'd64, 8'd3);
    core_write(8'd65, 8'd14);
    q.push_back(mk(5'd3, 5'd14, 1'b0, 1'b0));
    repeat (36) @(posedge clk);
    #1;
    check("still_running", int'(busy & ~mem_sel), 1);
    done_pulse();
    wait_report(20, 3);

    // Sanity-error and boundary cases.
    run_simple(8'd9, 8'd5, 5'd9, 5'd5, 1'b1);
    run_simple(8'd4, 8'd17, 5'd4, 5'd17, 1'b1);
    run_simple(8'd0, 8'd16, 5'd0, 5'd16, 1'b0);
    run_simple(8'd16, 8'd16, 5'd16, 5'd16, 1'b0);

`ifdef HAM_RUN_TIMEOUT_EN
    start_go();
    load_bytes(0, 8'h33);
    wait_fall(n);
    q.push_back(mk(5'd16, 5'd0, 1'b1, 1'b1));
    wait_report(200, 16);
`endif

    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
